// File: rtl/bitbal_gen.sv
// Balanced bit-pattern generator: emits an 8-bit word containing i_count ones, one bit per cycle, LSB first.
// Packed mode by default; define BITBAL_GEN_SPREAD_EN for accumulator-based spreading of the ones.
//   state  | meaning
//   IDLE   | waiting for i_start; illegal counts raise a one-cycle o_err
//   GEN    | one bit per cycle, index 0..7
//   DONE   | o_a holds the new word, o_done pulses, back to IDLE
module bitbal_gen (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_count,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_bit_out,
    output logic       o_bit_valid,
    output logic [7:0] o_a,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_count;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [7:0] r_a;
    logic       r_err;
    logic       w_accept;
    logic       w_illegal;
    logic       w_bit;

`ifdef BITBAL_GEN_SPREAD_EN
    logic [3:0] r_acc;
    logic [3:0] w_sum;
    logic [3:0] w_acc_nxt;

    // acc stays below 8 between cycles, so acc + count never exceeds 15 and bit 3 alone flags acc >= 8
    always_comb begin
        w_sum     = r_acc + r_count;
        w_bit     = w_sum[3];
        w_acc_nxt = {1'b0, w_sum[2:0]};
    end
`else
    assign w_bit = ({1'b0, r_idx} < r_count);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_illegal   = 1'b0;
        o_busy      = 1'b0;
        o_bit_valid = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_count <= 4'd8) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_GEN;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            S_GEN: begin
                o_busy      = 1'b1;
                o_bit_valid = 1'b1;
                if (r_idx == 3'd7) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt        = r_shift;
        w_shift_nxt[r_idx] = w_bit;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= 4'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_a     <= 8'h00;
            r_err   <= 1'b0;
`ifdef BITBAL_GEN_SPREAD_EN
            r_acc   <= 4'd0;
`endif
        end else begin
            r_err <= w_illegal;
            if (w_accept) begin
                r_count <= i_count;
                r_idx   <= 3'd0;
                r_shift <= 8'h00;
`ifdef BITBAL_GEN_SPREAD_EN
                r_acc   <= 4'd0;
`endif
            end else if (r_state == S_GEN) begin
                r_shift <= w_shift_nxt;
                r_idx   <= r_idx + 3'd1;
`ifdef BITBAL_GEN_SPREAD_EN
                r_acc   <= w_acc_nxt;
`endif
                // the last bit goes straight into o_a so the word is visible alongside o_done
                if (r_idx == 3'd7) begin
                    r_a <= w_shift_nxt;
                end
            end
        end
    end

    assign o_bit_out = o_bit_valid & w_bit;
    assign o_a       = r_a;
    assign o_err     = r_err;

endmodule

// File: tb/tb_bitbal_gen.sv
// Scoreboard bench for bitbal_gen: the driver queues expected bits/words/errors with their due cycle,
// a negedge monitor compares every cycle. Honours BITBAL_GEN_SPREAD_EN like the design.
module tb_bitbal_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic       start;
    logic       o_busy;
    logic       o_bit_out;
    logic       o_bit_valid;
    logic [7:0] o_a;
    logic       o_done;
    logic       o_err;

    always #5 clk = ~clk;

    bitbal_gen dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_count    (count),
        .i_start    (start),
        .o_busy     (o_busy),
        .o_bit_out  (o_bit_out),
        .o_bit_valid(o_bit_valid),
        .o_a        (o_a),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    typedef struct {
        int   t;
        logic b;
    } bit_t;

    typedef struct {
        int         t;
        bit         is_err;
        logic [7:0] a;
    } evt_t;

    bit_t       bq[$];
    evt_t       eq[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] model_a;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ones evenly spread: bit i is set when floor((i+1)n/8) steps past floor(i n/8)
    function automatic logic [7:0] ref_word(input int n);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) begin
`ifdef BITBAL_GEN_SPREAD_EN
            w[i] = (((i + 1) * n) / 8 - (i * n) / 8) != 0;
`else
            w[i] = (i < n);
`endif
        end
        return w;
    endfunction

    always @(negedge clk) begin
        logic exp_bv, exp_dn, exp_er;
        if (mon_en) begin
            exp_bv = (bq.size() > 0) && (bq[0].t == cyc);
            chk("bit_valid", o_bit_valid, exp_bv);
            if (exp_bv) begin
                chk("bit_out", o_bit_out, bq[0].b);
                chk("busy_in_gen", o_busy, 1);
                void'(bq.pop_front());
            end else if (bq.size() > 0 && bq[0].t < cyc) begin
                void'(bq.pop_front());
            end
            exp_dn = (eq.size() > 0) && (eq[0].t == cyc) && !eq[0].is_err;
            exp_er = (eq.size() > 0) && (eq[0].t == cyc) && eq[0].is_err;
            chk("done", o_done, exp_dn);
            chk("err", o_err, exp_er);
            if (exp_dn || exp_er) begin
                chk(exp_dn ? "word_a" : "a_kept_on_err", o_a, eq[0].a);
                chk("busy_at_event", o_busy, exp_dn);
                void'(eq.pop_front());
            end else if (eq.size() > 0 && eq[0].t < cyc) begin
                void'(eq.pop_front());
            end
            chk("exclusive", (int'(o_bit_valid) + int'(o_done) + int'(o_err)) <= 1, 1);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (o_busy !== 1'b0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (o_busy !== 1'b0) chk("idle_timeout", o_busy, 0);
    endtask

    task automatic req(input int n, input logic [7:0] w, output int cd);
        wait_idle();
        cd    = cyc;
        count = 4'(n);
        start = 1'b1;
        if (n <= 8) begin
            for (int i = 0; i < 8; i++) bq.push_back(bit_t'{cd + 1 + i, w[i]});
            eq.push_back(evt_t'{cd + 9, 1'b0, w});
            model_a = w;
        end else begin
            eq.push_back(evt_t'{cd + 1, 1'b1, model_a});
        end
        @(posedge clk); #1;
        start = 1'b0;
        count = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int         cd;
        int         n;
        int         k;
        logic [7:0] w3, w4;
`ifdef BITBAL_GEN_SPREAD_EN
        w3 = 8'b10100100;
        w4 = 8'b10101010;
`else
        w3 = 8'b00000111;
        w4 = 8'b00001111;
`endif
        reset   = 1'b1;
        start   = 1'b0;
        count   = 4'd0;
        model_a = 8'h00;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_a", o_a, 8'h00);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_bit_valid", o_bit_valid, 0);
        @(posedge clk); #1;

        req(3, w3, cd);
        req(4, w4, cd);
        req(8, 8'hFF, cd);
        req(0, 8'h00, cd);
        req(9, 8'h00, cd);
        @(posedge clk); #1;
        chk("err_single_cycle", o_err, 0);
        chk("busy_after_err", o_busy, 0);
        req(15, 8'h00, cd);

        // restart attempts while busy, including an illegal count, must be ignored
        req(5, ref_word(5), cd);
        while (cyc < cd + 5) begin @(posedge clk); #1; end
        start = 1'b1; count = 4'd9;
        @(posedge clk); #1;
        count = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;

        // abort a count=6 word at bit index 5
        req(6, ref_word(6), cd);
        while (cyc < cd + 6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        bq.delete();
        eq.delete();
        model_a = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_a", o_a, 8'h00);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        req(2, ref_word(2), cd);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 11);
            req(n, ref_word(n), cd);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        k = 0;
        while ((bq.size() + eq.size()) > 0 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("queue_drain", bq.size() + eq.size(), 0);
        chk("final_a", o_a, model_a);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
